// File: rtl/vga_mon_pkg.sv
// rtl/vga_mon_pkg.sv - shared timing defaults, state encoding and helpers for the VGA frame monitor
package vga_mon_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_TOTAL  = 800;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_TOTAL  = 525;
   localparam int RGB_W        = 24;
   localparam int COORD_W      = 10;
   localparam int CNT_W        = 12;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ALIGN    = 2'd1,
      LOCKED   = 2'd2
   } mon_state_t;

   // Counters stick at all-ones so a runaway line or frame can never alias a legal count.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// rtl/vga_frame_monitor_if.sv - VGA output bus as driven by the video generator and observed by the monitor
interface vga_frame_monitor_if;
   logic       vga_clk;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;

   modport master (output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b);
   modport slave  (input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_mon_edge.sv
// rtl/vga_mon_edge.sv - pixel-clock rise detect and HS/VS leading-edge detect on sampled sync
module vga_mon_edge #(
   parameter bit SYNC_POL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic vga_clk,
   input  logic vga_hs,
   input  logic vga_vs,
   output logic tick,
   output logic hs_edge,
   output logic vs_edge
);

   logic vga_clk_q;
   logic hs_q;
   logic vs_q;

   // Previous sync samples start at the idle level so a sync already asserted after reset counts once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_clk_q <= 1'b0;
         hs_q      <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
      end else begin
         vga_clk_q <= vga_clk;
         if (tick) begin
            hs_q <= vga_hs;
            vs_q <= vga_vs;
         end
      end
   end

   assign tick    = vga_clk & ~vga_clk_q;
   assign hs_edge = tick && (hs_q != SYNC_POL) && (vga_hs == SYNC_POL);
   assign vs_edge = tick && (vs_q != SYNC_POL) && (vga_vs == SYNC_POL);

endmodule

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - passive VGA timing checker and pixel capture; VGA_MON_SUM_EN adds a per-frame checksum
module vga_frame_monitor
   import vga_mon_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   vga_frame_monitor_if.slave  vga,
   input  logic                clear_err,
   output logic                pix_valid,
   output logic [COORD_W-1:0]  pix_x,
   output logic [COORD_W-1:0]  pix_y,
   output logic [RGB_W-1:0]    pix_rgb,
   output logic                locked,
   output logic                frame_done,
   output logic                h_err,
   output logic                v_err,
   output logic                act_err,
   output logic [31:0]         frame_sum
);

   mon_state_t         state;
   logic               tick, hs_edge, vs_edge;
   logic               h_mis;
   logic [CNT_W-1:0]   h_cnt, v_cnt, a_cnt, line_cnt;
   logic [CNT_W-1:0]   h_next, v_seen, lines_seen, a_base, y_base;
   logic               h_bad, a_bad, v_bad, l_bad, line_inc;
   logic               is_locked, capture;
   logic [RGB_W-1:0]   rgb;

   vga_mon_edge #(.SYNC_POL(SYNC_POL)) u_edge (
      .clk     (clk),
      .reset   (reset),
      .vga_clk (vga.vga_clk),
      .vga_hs  (vga.vga_hs),
      .vga_vs  (vga.vga_vs),
      .tick    (tick),
      .hs_edge (hs_edge),
      .vs_edge (vs_edge)
   );

   // HS is resolved before VS, so a coincident HS edge is counted in the frame that is closing.
   always_comb begin
      rgb        = {vga.vga_r, vga.vga_g, vga.vga_b};
      h_next     = sat_inc(h_cnt);
      line_inc   = hs_edge && (a_cnt != '0);
      h_bad      = hs_edge && (h_next != CNT_W'(H_TOTAL));
      a_bad      = hs_edge && (a_cnt != '0) && (a_cnt != CNT_W'(H_ACTIVE));
      v_seen     = hs_edge ? sat_inc(v_cnt) : v_cnt;
      lines_seen = line_inc ? sat_inc(line_cnt) : line_cnt;
      v_bad      = vs_edge && (v_seen != CNT_W'(V_TOTAL));
      l_bad      = vs_edge && (lines_seen != CNT_W'(V_ACTIVE));
      a_base     = hs_edge ? '0 : a_cnt;
      y_base     = vs_edge ? '0 : lines_seen;
      is_locked  = (state == LOCKED);
      capture    = tick && vga.vga_blank_n && is_locked;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= UNLOCKED;
         locked     <= 1'b0;
         h_mis      <= 1'b0;
         h_cnt      <= '0;
         v_cnt      <= '0;
         a_cnt      <= '0;
         line_cnt   <= '0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_rgb    <= '0;
         frame_done <= 1'b0;
         h_err      <= 1'b0;
         v_err      <= 1'b0;
         act_err    <= 1'b0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (tick) begin
            h_cnt    <= hs_edge ? '0 : h_next;
            v_cnt    <= vs_edge ? '0 : v_seen;
            line_cnt <= y_base;
            a_cnt    <= vga.vga_blank_n ? sat_inc(a_base) : a_base;
            if (capture) begin
               pix_valid <= 1'b1;
               pix_x     <= a_base[COORD_W-1:0];
               pix_y     <= y_base[COORD_W-1:0];
               pix_rgb   <= rgb;
            end
            case (state)
               UNLOCKED: begin
                  if (vs_edge) begin
                     state <= ALIGN;
                     h_mis <= 1'b0;
                  end
               end
               ALIGN: begin
                  if (vs_edge) begin
                     h_mis <= 1'b0;
                     if (!h_mis && !h_bad && (v_seen == CNT_W'(V_TOTAL))) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else if (h_bad) begin
                     h_mis <= 1'b1;
                  end
               end
               LOCKED: begin
                  frame_done <= vs_edge;
                  if (h_bad || a_bad || v_bad || l_bad) begin
                     state  <= UNLOCKED;
                     locked <= 1'b0;
                  end
               end
               default: begin
                  state  <= UNLOCKED;
                  locked <= 1'b0;
               end
            endcase
         end
         h_err   <= !clear_err && (h_err   || (is_locked && h_bad));
         v_err   <= !clear_err && (v_err   || (is_locked && v_bad));
         act_err <= !clear_err && (act_err || (is_locked && (a_bad || l_bad)));
      end
   end

`ifdef VGA_MON_SUM_EN
   logic [31:0] sum_acc;

   // A pixel landing on the VS tick opens the next frame's sum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_acc   <= '0;
         frame_sum <= '0;
      end else if (tick) begin
         if (vs_edge) begin
            sum_acc <= capture ? {8'd0, rgb} : 32'd0;
            if (is_locked) begin
               frame_sum <= sum_acc;
            end
         end else if (capture) begin
            sum_acc <= sum_acc + {8'd0, rgb};
         end
      end
   end
`else
   assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - scoreboard bench for vga_frame_monitor on a 4x3 active / 10x6 total raster
module tb_vga_frame_monitor;

   localparam int H_ACTIVE = 4;
   localparam int H_TOTAL  = 10;
   localparam int V_ACTIVE = 3;
   localparam int V_TOTAL  = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear_err = 1'b0;
   logic        pix_valid;
   logic [9:0]  pix_x, pix_y;
   logic [23:0] pix_rgb;
   logic        locked, frame_done, h_err, v_err, act_err;
   logic [31:0] frame_sum;

   int n_chk = 0;
   int n_fail = 0;
   int fno = 0;

   logic [43:0] px_q[$];
   logic [31:0] fd_q[$];

   vga_frame_monitor_if vga();

   vga_frame_monitor #(
      .H_ACTIVE (H_ACTIVE),
      .H_TOTAL  (H_TOTAL),
      .V_ACTIVE (V_ACTIVE),
      .V_TOTAL  (V_TOTAL),
      .SYNC_POL (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vga        (vga),
      .clear_err  (clear_err),
      .pix_valid  (pix_valid),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_rgb    (pix_rgb),
      .locked     (locked),
      .frame_done (frame_done),
      .h_err      (h_err),
      .v_err      (v_err),
      .act_err    (act_err),
      .frame_sum  (frame_sum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (pix_valid) begin
         if (px_q.size() == 0) check("pix_valid_unexpected", 64'(pix_valid), 64'd0);
         else check("pixel_xyrgb", 64'({pix_x, pix_y, pix_rgb}), 64'(px_q.pop_front()));
      end
      if (frame_done) begin
         if (fd_q.size() == 0) check("frame_done_unexpected", 64'(frame_done), 64'd0);
         else check("frame_sum", 64'(frame_sum), 64'(fd_q.pop_front()));
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_pix"}, 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'd0);
      check({tag, "_status"}, 64'({locked, frame_done, h_err, v_err, act_err, frame_sum}), 64'd0);
   endtask

   task automatic drive_hi(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
      vga.vga_clk     = 1'b1;
      vga.vga_hs      = hs;
      vga.vga_vs      = vs;
      vga.vga_blank_n = bl;
      {vga.vga_r, vga.vga_g, vga.vga_b} = rgb;
      @(negedge clk);
   endtask

   task automatic drive_lo();
      vga.vga_clk = 1'b0;
      @(negedge clk);
   endtask

   // mode 0: rgb pattern {x,y,frame}; mode 1: all 24'h000001; mode 2: all 24'hFFFFFF
   task automatic send_frame(input int nlines, input int bad_line, input int vs_off,
                             input bit px, input bit fd, input int mode, input bit rst_mid);
      logic [31:0] sum;
      logic [31:0] exp_sum;
      logic [23:0] rgb;
      logic        hs, vs, bl;
      bit          pxe, fde;
      int          vline, len;
      sum = 0; pxe = px; fde = fd;
      vline = nlines - 2;
      for (int l = 0; l < nlines; l++) begin
         len = (l == bad_line) ? H_TOTAL + 1 : H_TOTAL;
         for (int t = 0; t < len; t++) begin
            hs = (t < 2) ? 1'b0 : 1'b1;
            vs = ((l == vline && t >= vs_off) || (l == vline + 1 && t < vs_off)) ? 1'b0 : 1'b1;
            bl = (l < V_ACTIVE) && (t >= 3) && (t < 3 + H_ACTIVE);
            if (mode == 1) rgb = 24'h000001;
            else if (mode == 2) rgb = 24'hFFFFFF;
            else rgb = {8'(t - 3), 8'(l), 8'(fno)};
            if (rst_mid && l == 2 && t == 0) reset = 1'b1;
            if (bl && pxe) begin
               px_q.push_back({10'(t - 3), 10'(l), rgb});
               sum = sum + {8'd0, rgb};
            end
            if (fde && l == vline && t == vs_off) begin
`ifdef VGA_MON_SUM_EN
               exp_sum = (mode == 1) ? 32'd12 : (mode == 2) ? 32'd201326580 : sum;
`else
               exp_sum = 32'd0;
`endif
               fd_q.push_back(exp_sum);
            end
            drive_hi(hs, vs, bl, rgb);
            if (bad_line >= 0 && l == bad_line + 1 && t == 0) begin
               check("h_err_after_long_line", 64'(h_err), 64'd1);
               check("locked_after_long_line", 64'(locked), 64'd0);
            end
            if (rst_mid && l == 1 && t == 4) begin
               #2 reset = 1'b0;
               #1 check_zero("async_reset");
               pxe = 1'b0;
               fde = 1'b0;
            end
            drive_lo();
         end
      end
      fno++;
   endtask

   task automatic end_checks(input bit exp_lock, input bit exp_h, input bit exp_v);
      check("locked", 64'(locked), 64'(exp_lock));
      check("h_err", 64'(h_err), 64'(exp_h));
      check("v_err", 64'(v_err), 64'(exp_v));
      check("act_err", 64'(act_err), 64'd0);
      check("pixels_outstanding", 64'(px_q.size()), 64'd0);
      check("frame_done_outstanding", 64'(fd_q.size()), 64'd0);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      vga.vga_clk = 1'b0;
      vga.vga_hs = 1'b1;
      vga.vga_vs = 1'b1;
      vga.vga_blank_n = 1'b0;
      vga.vga_r = 8'd0;
      vga.vga_g = 8'd0;
      vga.vga_b = 8'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      send_frame(6, -1, 5, 0, 0, 0, 0); end_checks(0, 0, 0);
      send_frame(6, -1, 5, 0, 0, 0, 0); end_checks(1, 0, 0);
      send_frame(6, -1, 5, 1, 1, 0, 0); end_checks(1, 0, 0);
      send_frame(6, -1, 5, 1, 1, 0, 0); end_checks(1, 0, 0);

      send_frame(6, 3, 5, 1, 0, 0, 0);  end_checks(0, 1, 0);
      send_frame(6, -1, 5, 0, 0, 0, 0); end_checks(1, 1, 0);
      send_frame(6, -1, 5, 1, 1, 1, 0); end_checks(1, 1, 0);
      pulse_clear();                    end_checks(1, 0, 0);

      send_frame(7, -1, 5, 1, 1, 2, 0); end_checks(0, 0, 1);
      pulse_clear();                    end_checks(0, 0, 0);
      send_frame(6, -1, 5, 0, 0, 0, 0); end_checks(0, 0, 0);
      send_frame(6, -1, 5, 0, 0, 0, 0); end_checks(1, 0, 0);
      send_frame(6, -1, 5, 1, 1, 0, 0); end_checks(1, 0, 0);

      send_frame(6, -1, 0, 1, 1, 0, 0); end_checks(1, 0, 0);
      send_frame(6, -1, 0, 1, 1, 0, 0); end_checks(1, 0, 0);
      send_frame(6, -1, 5, 1, 1, 0, 0); end_checks(1, 0, 0);

      send_frame(6, -1, 5, 1, 1, 0, 1); end_checks(0, 0, 0);
      send_frame(6, -1, 5, 0, 0, 0, 0); end_checks(1, 0, 0);
      send_frame(6, -1, 5, 1, 1, 0, 0); end_checks(1, 0, 0);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
